// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin registered arbiter.
package rr_reg_arbiter_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_reg_arbiter_if.sv
// Requester-side and output-side handshake bundle of the arbiter.
interface rr_reg_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic                       flush;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ*WIDTH-1:0]   req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_data;
    logic [SRC_W-1:0]           out_src;
    logic                       out_last;

    modport master (
        output flush, req_valid, req_last, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src, out_last
    );

    modport slave (
        input  flush, req_valid, req_last, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src, out_last
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping.
module rr_priority_pick #(
    parameter  int NUM_REQ = 4,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               any_gnt
);

    int               sum;
    logic [SRC_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        sum     = 0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            idx = SRC_W'(sum);
            if (!any_gnt && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                any_gnt  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter with burst lock feeding a single registered output beat.
//   state | meaning
//   ARB   | any valid requester may win, scanning from ptr
//   HOLD  | burst in progress; only owner may transfer until its last beat
module rr_reg_arbiter
    import rr_reg_arbiter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
) (
    input logic            clk,
    input logic            rst_n,
    rr_reg_arbiter_if.slave bus
);

    localparam int SRC_W = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [SRC_W-1:0]   owner_q, owner_d;

    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [SRC_W-1:0]   out_src_q;
    logic               out_last_q;

    logic [NUM_REQ-1:0] owner_mask;
    logic [NUM_REQ-1:0] req_masked;
    logic [NUM_REQ-1:0] gnt;
    logic [SRC_W-1:0]   gnt_idx;
    logic               any_gnt;
    logic               load_en;
    logic               xfer;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_last;

    assign owner_mask = NUM_REQ'(1) << owner_q;
    assign req_masked = (state_q == HOLD) ? (bus.req_valid & owner_mask) : bus.req_valid;

    rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (req_masked),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign load_en       = !out_valid_q || bus.out_ready;
    assign xfer          = any_gnt && load_en && !bus.flush;
    assign bus.req_ready = (load_en && !bus.flush) ? gnt : '0;

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_data = bus.req_data[i*WIDTH +: WIDTH];
                sel_last = bus.req_last[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (bus.flush) begin
            state_d = ARB;
        end else if (xfer) begin
            case (state_q)
                ARB: begin
                    if (sel_last) begin
                        ptr_d = SRC_W'(next_idx(int'(gnt_idx), NUM_REQ));
                    end else begin
                        owner_d = gnt_idx;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (sel_last) begin
                        ptr_d   = SRC_W'(next_idx(int'(owner_q), NUM_REQ));
                        state_d = ARB;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // Drain and load may share an edge, so a new beat simply overwrites the departing one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_src_q   <= gnt_idx;
            out_last_q  <= sel_last;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_last  = out_last_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.req_ready));

    a_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && !bus.out_ready) |=> $stable(out_data_q));

    a_hold_owner_only: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == HOLD) |-> ((bus.req_ready & ~owner_mask) == '0));

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: directed scenarios with literal expectations plus randomized traffic vs a behavioural model.
module tb_rr_reg_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_reg_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

    rr_reg_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integers describing who owns the stage and what it holds.
    int         m_ptr, m_owner, m_src, m_g;
    bit         m_hold, m_ov, m_last, m_load;
    logic [7:0] m_data;
    logic [3:0] m_rdy;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            m_ptr = 0; m_owner = 0; m_hold = 0; m_ov = 0;
            m_data = '0; m_src = 0; m_last = 0;
        end else begin
            chk("model_out_valid", 32'(bus.out_valid), 32'(m_ov));
            if (m_ov) begin
                chk("model_out_data", 32'(bus.out_data), 32'(m_data));
                chk("model_out_src",  32'(bus.out_src),  32'(m_src));
                chk("model_out_last", 32'(bus.out_last), 32'(m_last));
            end
            m_g = -1;
            if (m_hold) begin
                if (bus.req_valid[m_owner]) m_g = m_owner;
            end else begin
                for (int k = 0; k < NUM_REQ; k++)
                    if (m_g < 0 && bus.req_valid[(m_ptr + k) % NUM_REQ]) m_g = (m_ptr + k) % NUM_REQ;
            end
            m_load = !m_ov || bus.out_ready;
            if (!(m_load && !bus.flush)) m_g = -1;
            m_rdy = (m_g >= 0) ? 4'(1 << m_g) : 4'b0;
            chk("model_req_ready", 32'(bus.req_ready), 32'(m_rdy));
            if (bus.flush) begin
                m_ov = 0; m_hold = 0;
            end else if (m_g >= 0) begin
                m_ov = 1;
                m_data = bus.req_data[m_g*WIDTH +: WIDTH];
                m_src = m_g;
                m_last = bus.req_last[m_g];
                if (m_last) begin
                    m_ptr = (m_g + 1) % NUM_REQ; m_hold = 0;
                end else begin
                    m_hold = 1; m_owner = m_g;
                end
            end else if (bus.out_ready) begin
                m_ov = 0;
            end
        end
    end

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                         input logic ordy, input logic fl);
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    localparam logic [31:0] SEQ_DATA = 32'h13121110;

    logic [3:0] exp2_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] exp2_dat [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    logic       t3_last2 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] exp3_rdy [5] = '{4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
    int         exp3_src [5] = '{1, 2, 2, 2, 3};

    initial begin
        drive(4'b0, 4'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_data",  32'(bus.out_data),  32'd0);
        chk("reset_out_src",   32'(bus.out_src),   32'd0);

        // 1: idle
        repeat (10) begin
            @(negedge clk);
            drive(4'b0, 4'b0, 32'h0, 1'b1, 1'b0);
            #3 chk("idle_ready", 32'(bus.req_ready), 32'd0);
        end

        // 2: all valid single beats rotate 0,1,2,3,0
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 5) drive(4'b1111, 4'b1111, SEQ_DATA, 1'b1, 1'b0);
            else       drive(4'b0000, 4'b1111, SEQ_DATA, 1'b1, 1'b0);
            #3;
            if (k < 5) chk("rot_ready", 32'(bus.req_ready), 32'(exp2_rdy[k]));
            if (k > 0) chk("rot_data",  32'(bus.out_data),  32'(exp2_dat[k-1]));
        end

        // 3: burst lock on requester 2 (ptr is 1, so requester 1 goes first)
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 5) drive(4'b1111, {1'b1, t3_last2[k], 2'b11}, SEQ_DATA, 1'b1, 1'b0);
            else       drive(4'b0000, 4'b1111, SEQ_DATA, 1'b1, 1'b0);
            #3;
            if (k < 5) chk("burst_ready", 32'(bus.req_ready), 32'(exp3_rdy[k]));
            if (k > 0) chk("burst_src",   32'(bus.out_src),   32'(exp3_src[k-1]));
        end

        // 4: backpressure holds 8'hA5
        @(negedge clk);
        drive(4'b0001, 4'b0001, 32'h000000A5, 1'b1, 1'b0);
        #3 chk("bp_first_ready", 32'(bus.req_ready), 32'd1);
        repeat (5) begin
            @(negedge clk);
            drive(4'b0001, 4'b0001, 32'h0000005A, 1'b0, 1'b0);
            #3;
            chk("bp_hold_data",  32'(bus.out_data),  32'hA5);
            chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        drive(4'b0001, 4'b0001, 32'h0000005A, 1'b1, 1'b0);
        #3 chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        drive(4'b0000, 4'b0001, 32'h0, 1'b1, 1'b0);
        #3;
        chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_next_data",  32'(bus.out_data),  32'h5A);

        // 5: flush in the middle of requester 1's burst
        @(negedge clk);
        drive(4'b0011, 4'b0001, 32'h0000BB00, 1'b1, 1'b0);
        #3 chk("fl_start_ready", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        drive(4'b0011, 4'b0001, 32'h0000BB00, 1'b1, 1'b1);
        #3 chk("fl_flush_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        drive(4'b0001, 4'b0001, 32'h000000C3, 1'b1, 1'b0);
        #3;
        chk("fl_after_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_after_ready", 32'(bus.req_ready), 32'b0001);
        @(negedge clk);
        drive(4'b0000, 4'b0001, 32'h0, 1'b1, 1'b0);
        #3 chk("fl_after_src", 32'(bus.out_src), 32'd0);

        // 6: async reset while requester 2 holds a burst with a beat waiting
        @(negedge clk);
        drive(4'b0100, 4'b0000, 32'h00770000, 1'b1, 1'b0);
        #3 chk("rst_hold_ready", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        drive(4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0);
        #3 chk("rst_pre_src", 32'(bus.out_src), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_async_data",  32'(bus.out_data),  32'd0);
        chk("rst_async_src",   32'(bus.out_src),   32'd0);
        chk("rst_async_last",  32'(bus.out_last),  32'd0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        drive(4'b1111, 4'b1111, SEQ_DATA, 1'b1, 1'b0);
        #3 chk("rst_restart_ready", 32'(bus.req_ready), 32'b0001);
        @(negedge clk);
        drive(4'b0000, 4'b1111, SEQ_DATA, 1'b1, 1'b0);
        #3 chk("rst_restart_data", 32'(bus.out_data), 32'h10);

        // Randomized traffic, checked every cycle by the model
        repeat (3000) begin
            @(negedge clk);
            drive(4'($urandom), 4'($urandom) | 4'($urandom), 32'($urandom),
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
        end

        @(negedge clk);
        drive(4'b0, 4'b0, 32'h0, 1'b1, 1'b0);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
